// File: rtl/wb_ifmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_ifmem_arbiter_if
//   One Wishbone link (request + response) between a master and a slave.
//   Used three times around the instruction/data memory arbiter: the fetch
//   stage link, the memory stage link and the shared memory bus link.
//
// Signals
//   adr   [31:0]  address                 master -> slave
//   wdat  [31:0]  write data              master -> slave
//   we            write enable            master -> slave
//   sel   [3:0]   byte select             master -> slave
//   stb, cyc      request strobes         master -> slave
//   rdat  [31:0]  read data               slave  -> master
//   ack, err, rty transfer responses      slave  -> master
//
// Modports
//   master : the side that issues requests
//   slave  : the side that answers them
// ---------------------------------------------------------------------------
interface wb_ifmem_arbiter_if;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        cyc;
  logic [31:0] rdat;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output adr, wdat, we, sel, stb, cyc,
    input  rdat, ack, err, rty
  );

  modport slave (
    input  adr, wdat, we, sel, stb, cyc,
    output rdat, ack, err, rty
  );
endinterface

// File: rtl/wb_ifmem_arbiter.sv
// ---------------------------------------------------------------------------
// wb_ifmem_arbiter
//   Two-master Wishbone arbiter sharing the instruction/data memory bus
//   between the fetch stage (m0) and the memory stage (m1). One transfer is
//   granted at a time and arbitration is redone after every completion.
//   The request path is a pure mux of the granted master, the response path
//   is a pure mux back to it (zero added latency). A watchdog aborts a
//   granted transfer that sees no response for TIMEOUT_CYCLES cycles by
//   returning err to the master.
//
// Parameters
//   TIMEOUT_CYCLES  cycles a granted transfer may wait for a response
//                   (0 disables the watchdog), default 255
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   m0       slave modport   fetch-stage link (master 0)
//   m1       slave modport   memory-stage link (master 1)
//   s        master modport  shared memory bus
//   grant_o  out  [1:0] one-hot grant: 01 = m0, 10 = m1, 00 = idle
//
// Build option
//   WB_ARB_ROUND_ROBIN_EN  defined   : round-robin tie-break (master not
//                                      granted last wins a tie)
//                          undefined : fixed priority m1 > m0
// ---------------------------------------------------------------------------
module wb_ifmem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  wb_ifmem_arbiter_if.slave  m0,
  wb_ifmem_arbiter_if.slave  m1,
  wb_ifmem_arbiter_if.master s,
  output logic [1:0]         grant_o
);

  // Counter is kept at least 1 bit wide so a disabled watchdog still elaborates.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next;
  state_t           w_arb;
  logic [CNT_W-1:0] r_cnt;

  logic w_req0;
  logic w_req1;
  logic w_gnt;
  logic w_cyc_x;
  logic w_resp;
  logic w_to;
  logic w_to_err;
  logic w_abort;
  logic w_done;

  assign w_req0  = m0.stb & m0.cyc;
  assign w_req1  = m1.stb & m1.cyc;
  assign w_gnt   = (r_state != ST_IDLE);
  assign w_cyc_x = (r_state == ST_GNT1) ? m1.cyc : m0.cyc;
  assign w_resp  = s.ack | s.err | s.rty;

  // The timeout cycle depends only on the counter, never on the slave
  // response, so a combinational slave (ack = stb) cannot form a loop.
  assign w_to     = (TIMEOUT_CYCLES != 0) && w_gnt && (r_cnt == CNT_W'(TIMEOUT_CYCLES));
  // A real ack (or retry) in the timeout cycle takes precedence over the
  // synthesized error.
  assign w_to_err = w_to & ~s.ack & ~s.rty;
  assign w_abort  = w_gnt & ~w_cyc_x;
  assign w_done   = w_gnt & w_cyc_x & (w_resp | w_to);

  // Arbitration over the live requests.
`ifdef WB_ARB_ROUND_ROBIN_EN
  logic r_last_m1;

  // Remembers which master completed last; timeouts count as completions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_m1 <= 1'b0;
    end else if (w_done) begin
      r_last_m1 <= (r_state == ST_GNT1);
    end
  end

  always_comb begin
    w_arb = ST_IDLE;
    if (w_req0 && w_req1) begin
      w_arb = r_last_m1 ? ST_GNT0 : ST_GNT1;
    end else if (w_req1) begin
      w_arb = ST_GNT1;
    end else if (w_req0) begin
      w_arb = ST_GNT0;
    end
  end
`else
  always_comb begin
    w_arb = ST_IDLE;
    if (w_req1) begin
      w_arb = ST_GNT1;
    end else if (w_req0) begin
      w_arb = ST_GNT0;
    end
  end
`endif

  // Grant state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. An abort wins over a same-cycle completion.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = w_arb;
      ST_GNT0,
      ST_GNT1: begin
        if (w_abort) begin
          w_next = ST_IDLE;
        end else if (w_done) begin
          w_next = w_arb;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request path towards the shared bus.
  always_comb begin
    s.adr  = '0;
    s.wdat = '0;
    s.we   = 1'b0;
    s.sel  = '0;
    s.stb  = 1'b0;
    s.cyc  = 1'b0;
    case (r_state)
      ST_GNT0: begin
        s.adr  = m0.adr;
        s.wdat = m0.wdat;
        s.we   = m0.we;
        s.sel  = m0.sel;
        s.cyc  = m0.cyc;
        s.stb  = m0.stb & m0.cyc & ~w_to;
      end
      ST_GNT1: begin
        s.adr  = m1.adr;
        s.wdat = m1.wdat;
        s.we   = m1.we;
        s.sel  = m1.sel;
        s.cyc  = m1.cyc;
        s.stb  = m1.stb & m1.cyc & ~w_to;
      end
      default: ;
    endcase
  end

  // Response path: read data broadcast, handshakes to the granted master only.
  assign m0.rdat = s.rdat;
  assign m1.rdat = s.rdat;

  assign m0.ack = (r_state == ST_GNT0) & s.ack;
  assign m0.err = (r_state == ST_GNT0) & (s.err | w_to_err);
  assign m0.rty = (r_state == ST_GNT0) & s.rty;

  assign m1.ack = (r_state == ST_GNT1) & s.ack;
  assign m1.err = (r_state == ST_GNT1) & (s.err | w_to_err);
  assign m1.rty = (r_state == ST_GNT1) & s.rty;

  assign grant_o = r_state;

  // Watchdog: restarts on every grant entry, counts silent grant cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!w_gnt || w_done || w_abort) begin
      r_cnt <= '0;
    end else if (r_cnt != {CNT_W{1'b1}}) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_ifmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_ifmem_arbiter
//   Directed bench for wb_ifmem_arbiter with a cycle-level reference model
//   (who holds the bus, how long it has waited, who finished last) checked
//   on every falling edge, plus hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_wb_ifmem_arbiter;
  localparam int TO = 4;
`ifdef WB_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_ifmem_arbiter_if m0if();
  wb_ifmem_arbiter_if m1if();
  wb_ifmem_arbiter_if sbif();
  logic [1:0] grant;

  wb_ifmem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0if),
    .m1      (m1if),
    .s       (sbif),
    .grant_o (grant)
  );

  // Slave: zero-wait (ack = stb) or manually driven responses.
  logic        sl_zw;
  logic        sl_ack;
  logic        sl_err;
  logic        sl_rty;
  logic [31:0] sl_dat;
  assign sbif.ack  = sl_zw ? sbif.stb : sl_ack;
  assign sbif.err  = sl_err;
  assign sbif.rty  = sl_rty;
  assign sbif.rdat = sl_dat;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sl_dat = sl_dat + 32'h01010101;
  endtask

  task automatic m0_set(input bit req, input logic [31:0] a);
    m0if.cyc  = req;
    m0if.stb  = req;
    m0if.adr  = a;
    m0if.wdat = 32'h0;
    m0if.we   = 1'b0;
    m0if.sel  = 4'hF;
  endtask

  task automatic m1_set(input bit req, input bit we, input logic [3:0] sel,
                        input logic [31:0] a, input logic [31:0] d);
    m1if.cyc  = req;
    m1if.stb  = req;
    m1if.we   = we;
    m1if.sel  = sel;
    m1if.adr  = a;
    m1if.wdat = d;
  endtask

  // Reference model: mg = bus owner (0 none, 1 = M0, 2 = M1),
  // mw = silent cycles spent in the current grant, ml = last completer.
  int mg = 0;
  int mw = 0;
  int ml = 1;
  bit armed = 1'b0;

  function automatic int pick(input bit r0, input bit r1, input int last);
    if (r0 && r1) return RR ? ((last == 2) ? 1 : 2) : 2;
    if (r1) return 2;
    if (r0) return 1;
    return 0;
  endfunction

  always @(posedge clk) if (rst) armed <= 1'b1;

  always @(negedge clk) begin
    bit          r0, r1, cx, to_now;
    logic [31:0] ea, ed;
    logic [6:0]  ectl;
    logic [2:0]  tresp, e0, e1;
    logic [1:0]  egr;
    r0     = m0if.stb & m0if.cyc;
    r1     = m1if.stb & m1if.cyc;
    cx     = (mg == 2) ? m1if.cyc : (mg == 1) ? m0if.cyc : 1'b0;
    to_now = (mg != 0) && (TO != 0) && (mw == TO);
    ea = 32'h0; ed = 32'h0; ectl = 7'h0;
    if (mg == 1) begin
      ea = m0if.adr; ed = m0if.wdat;
      ectl = {m0if.we, m0if.sel, r0 & ~to_now, m0if.cyc};
    end else if (mg == 2) begin
      ea = m1if.adr; ed = m1if.wdat;
      ectl = {m1if.we, m1if.sel, r1 & ~to_now, m1if.cyc};
    end
    tresp = {sbif.ack, sbif.err | (to_now & ~sbif.ack & ~sbif.rty), sbif.rty};
    e0  = (mg == 1) ? tresp : 3'b000;
    e1  = (mg == 2) ? tresp : 3'b000;
    egr = (mg == 1) ? 2'b01 : (mg == 2) ? 2'b10 : 2'b00;
    if (armed) begin
      chk("grant",   grant, egr);
      chk("s_adr",   sbif.adr, ea);
      chk("s_dat",   sbif.wdat, ed);
      chk("s_ctl",   {sbif.we, sbif.sel, sbif.stb, sbif.cyc}, ectl);
      chk("m0_resp", {m0if.ack, m0if.err, m0if.rty}, e0);
      chk("m1_resp", {m1if.ack, m1if.err, m1if.rty}, e1);
      chk("rdat",    {m0if.rdat, m1if.rdat}, {sl_dat, sl_dat});
    end
    if (rst) begin
      mg = 0; mw = 0; ml = 1;
    end else if (mg == 0) begin
      mg = pick(r0, r1, ml); mw = 0;
    end else if (!cx) begin
      mg = 0; mw = 0;
    end else if (sbif.ack || sbif.err || sbif.rty || to_now) begin
      ml = mg; mg = pick(r0, r1, ml); mw = 0;
    end else begin
      mw = mw + 1;
    end
  end

  initial begin
    rst = 1'b1;
    sl_zw = 1'b1; sl_ack = 1'b0; sl_err = 1'b0; sl_rty = 1'b0;
    sl_dat = 32'h5A000000;
    m0_set(1'b1, 32'h80000000);
    m1_set(1'b1, 1'b0, 4'hF, 32'h20000000, 32'h0);

    // Reset with both masters requesting
    tick(); #2; chk("rst_gnt_a", grant, 2'b00);
    tick(); #2; chk("rst_gnt_b", grant, 2'b00); chk("rst_m0ack", m0if.ack, 1'b0);
    rst = 1'b0;
    tick(); #2;
    chk("first_gnt", grant, 2'b10);
    chk("first_m0ack", m0if.ack, 1'b0);
    chk("first_m1ack", m1if.ack, 1'b1);
    // Contention with a zero-wait slave
    tick(); #2;
    chk("cont_2", grant, RR ? 2'b01 : 2'b10);
    chk("cont_2_m0ack", m0if.ack, RR ? 1'b1 : 1'b0);
    tick(); #2; chk("cont_3", grant, 2'b10);
    repeat (3) tick();

    // Both drop: abort then idle
    m0_set(1'b0, 32'h0);
    m1_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick(); tick(); #2; chk("idle_gnt", grant, 2'b00);

    // Store via M1, manually acknowledged
    sl_zw = 1'b0; sl_ack = 1'b0;
    m1_set(1'b1, 1'b1, 4'b0011, 32'h10000000, 32'hDEADBEEF);
    tick(); #2;
    chk("st_gnt", grant, 2'b10);
    chk("st_adr", sbif.adr, 32'h10000000);
    chk("st_dat", sbif.wdat, 32'hDEADBEEF);
    chk("st_we_sel_stb", {sbif.we, sbif.sel, sbif.stb}, 6'b1_0011_1);
    chk("st_noack", m1if.ack, 1'b0);
    sl_ack = 1'b1; #1;
    chk("st_ack", {m1if.ack, m1if.err, m0if.ack}, 3'b100);

    // Abort: M1 waits then drops cyc; M0 starts requesting
    tick(); sl_ack = 1'b0;
    m1_set(1'b1, 1'b0, 4'hF, 32'h10000040, 32'h0);
    tick(); tick();
    m1_set(1'b0, 1'b0, 4'hF, 32'h10000040, 32'h0);
    m0_set(1'b1, 32'h80000100);
    #2; chk("ab_scyc", sbif.cyc, 1'b0); chk("ab_m1resp", {m1if.ack, m1if.err}, 2'b00);
    tick(); #2; chk("ab_gnt", grant, 2'b00);

    // Timeout: silent slave, err on 5th grant cycle
    for (int i = 1; i <= 5; i++) begin
      tick(); #2;
      chk("to_gnt", grant, 2'b01);
      chk("to_err", m0if.err, (i == 5));
      chk("to_stb", sbif.stb, (i != 5));
    end
    tick(); #2;
    chk("to_regnt", grant, 2'b01); chk("to_reerr", m0if.err, 1'b0); chk("to_restb", sbif.stb, 1'b1);

    // Real ack in the timeout cycle wins over err
    repeat (3) tick();
    tick(); sl_ack = 1'b1; #2;
    chk("late_ack", {m0if.ack, m0if.err}, 2'b10);
    tick(); sl_ack = 1'b0; sl_err = 1'b1; #2;
    chk("slv_err", {m0if.err, m1if.err}, 2'b10);
    tick(); sl_err = 1'b0; sl_rty = 1'b1; #2;
    chk("slv_rty", {m0if.rty, m0if.ack}, 2'b10);
    tick(); sl_rty = 1'b0; sl_zw = 1'b1;

    // IF-only fetch stream, one ack per cycle
    for (int i = 0; i < 6; i++) begin
      m0_set(1'b1, 32'h80000000 + 32'(4 * i));
      #2;
      chk("if_gnt", grant, 2'b01);
      chk("if_ack", m0if.ack, 1'b1);
      chk("if_adr", sbif.adr, 32'h80000000 + 32'(4 * i));
      tick();
    end

    // Reset mid-transfer
    rst = 1'b1;
    tick(); #2; chk("mid_rst_gnt", grant, 2'b00); chk("mid_rst_ack", m0if.ack, 1'b0);
    rst = 1'b0;
    tick(); #2; chk("post_rst_gnt", grant, 2'b01);

    m0_set(1'b0, 32'h0);
    tick(); tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
